funcion_inversa: RTL and testbench
==================================

// Module: funcion_inversa
// PURPOSE
//  Sequential inverse of the 2-function math unit: given an 8-bit result Y and the same
//  operation selector, recovers x such that Y = 2*x+2 (sel=01) or Y = x*x (sel=10).
//  Does a linear candidate search, one candidate per clock, with start/busy/done handshake.
//  Sits between a result source (switches/register) and the binary-to-7-seg decoder path.
// PARAMETERS
//  N_BITS  4  width of recovered x; Y is 2*N_BITS wide; legal range N_BITS >= 2
// PORTS
//  clk                input   1         system clock, rising edge
//  rst_n              input   1         asynchronous, active-low reset
//  start              input   1         request pulse; sampled only in IDLE
//  resultado          input   2*N_BITS  Y value to invert; latched on accepted start
//  selectorOperacion  input   2         01: Y=2x+2, 10: Y=x*x, 00/11: invalid; latched with Y
//  binario            output  N_BITS    recovered x (registered)
//  encontrado         output  1         1 = exact inverse found
//  busy               output  1         1 while in SEARCH
//  done               output  1         one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; binario=0, encontrado=0, busy=0, done=0; cand=0.
//  - FSM states: IDLE -> SEARCH -> DONE -> IDLE.
//  - IDLE: start=1 at an edge latches Y and sel.
//      Valid sel: go to SEARCH, cand=0, busy=1.
//      Invalid sel (00/11): go straight to DONE with binario=0, encontrado=0.
//  - SEARCH, each edge: f = f_sel(cand), computed in 2*N_BITS+1 bits (no wrap).
//      f == Y                  -> binario=cand, encontrado=1, go DONE.
//      f > Y, or cand==2^N-1
//        with f != Y           -> not-found result (see CONFIGURATION), go DONE.
//      otherwise               -> cand=cand+1.
//      Both functions are monotonic, so early exit on f > Y is exact.
//  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
//  - Latency: exact hit at x=k -> done high after edge k+2 (the start-sampling edge is edge 0).
//      Invalid sel -> done high after edge 1.
//  - binario/encontrado hold their value from DONE until the next accepted start.
//      They are updated only on the DONE-entry edge.
//  - start while busy or in DONE: ignored, no queueing.
//      Inputs resultado/selectorOperacion may change freely after the start edge.
//  - Y=0 with sel=10: exact at cand=0 (done after edge 2).
//      Y<2 with sel=01: f(0)=2 > Y, so not found after edge 2.
//  - Reset mid-SEARCH: immediate abort; no done pulse; outputs return to reset values.
// CONFIGURATION
//  INV_FLOOR_EN defined: on not-found, binario = largest cand with f(cand) < Y.
//    This is cand-1 on f > Y exit, or cand on exhausting the range; 0 if f(0) > Y.
//    encontrado=0.
//  INV_FLOOR_EN undefined: on not-found, binario=0, encontrado=0.
//  Exact-hit behaviour and latency are identical in both builds.
// TESTING
//  1 sel=10, Y=49, start -> binario=7, encontrado=1, done after edge 9, busy high edges 1..8.
//  2 sel=01, Y=20, start -> binario=9, encontrado=1, done after edge 11.
//    sel=01, Y=32 -> binario=15, encontrado=1.
//  3 sel=10, Y=50 -> encontrado=0, done after edge 10 (f(8)=64 > 50).
//    Floor build: binario=7. Default build: binario=0.
//  4 sel=10, Y=226 -> range exhausted at cand=15, done after edge 17, encontrado=0.
//    Floor build: binario=15. Default build: binario=0.
//  5 sel=00 or 11, any Y -> done after edge 1, binario=0, encontrado=0, busy never high.
//  6 start sel=10, Y=225; pulse start again at edge 3; assert rst_n=0 at edge 5
//    -> second start ignored; outputs zero immediately; no done; next start works normally.

Source files
------------

// File: rtl/funcion_inversa.sv
// rtl/funcion_inversa.sv - sequential inverse of Y=2x+2 / Y=x*x by linear candidate search
// Optional build macro INV_FLOOR_EN: on not-found, report the largest cand with f(cand) < Y.
module funcion_inversa #(
  parameter int N_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*N_BITS-1:0]   resultado,
  input  logic [1:0]            selectorOperacion,
  output logic [N_BITS-1:0]     binario,
  output logic                  encontrado,
  output logic                  busy,
  output logic                  done
);

  localparam int W = 2*N_BITS + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state_q, state_d;
  logic [N_BITS-1:0]     cand_q, cand_d;
  logic [2*N_BITS-1:0]   y_q, y_d;
  logic [1:0]            sel_q, sel_d;
  logic [N_BITS-1:0]     binario_q, binario_d;
  logic                  encontrado_q, encontrado_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [W-1:0]          cand_ext, y_ext, f_val;

  // f is evaluated one bit wider than Y so 2x+2 and x*x never wrap before the compare.
  always_comb begin
    cand_ext = {{(N_BITS+1){1'b0}}, cand_q};
    y_ext    = {1'b0, y_q};
    if (sel_q == 2'b01) f_val = (cand_ext << 1) + W'(2);
    else                f_val = cand_ext * cand_ext;
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    y_d          = y_q;
    sel_d        = sel_q;
    binario_d    = binario_q;
    encontrado_d = encontrado_q;
    // busy/done are registered views of the state, so they trail it by one edge.
    busy_d       = (state_q == SEARCH);
    done_d       = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          y_d   = resultado;
          sel_d = selectorOperacion;
          if (selectorOperacion == 2'b01 || selectorOperacion == 2'b10) begin
            state_d = SEARCH;
            cand_d  = '0;
          end else begin
            state_d      = DONE;
            binario_d    = '0;
            encontrado_d = 1'b0;
          end
        end
      end
      SEARCH: begin
        if (f_val == y_ext) begin
          state_d      = DONE;
          binario_d    = cand_q;
          encontrado_d = 1'b1;
        end else if (f_val > y_ext || cand_q == {N_BITS{1'b1}}) begin
          state_d      = DONE;
          encontrado_d = 1'b0;
`ifdef INV_FLOOR_EN
          if (f_val > y_ext) binario_d = (cand_q == '0) ? '0 : cand_q - N_BITS'(1);
          else               binario_d = cand_q;
`else
          binario_d = '0;
`endif
        end else begin
          cand_d = cand_q + N_BITS'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      y_q          <= '0;
      sel_q        <= '0;
      binario_q    <= '0;
      encontrado_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      y_q          <= y_d;
      sel_q        <= sel_d;
      binario_q    <= binario_d;
      encontrado_q <= encontrado_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign binario    = binario_q;
  assign encontrado = encontrado_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_funcion_inversa.sv
// tb/tb_funcion_inversa.sv - directed bench for funcion_inversa with a search-level reference model
module tb_funcion_inversa;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] resultado;
  logic [1:0] selectorOperacion;
  logic [3:0] binario;
  logic       encontrado;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  bit chk_en = 1'b0;
  int exp_bin = 0;
  int exp_enc = 0;
  int exp_busy = 0;
  int exp_done = 0;

  funcion_inversa #(.N_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resultado(resultado),
    .selectorOperacion(selectorOperacion), .binario(binario),
    .encontrado(encontrado), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Result and done-latency (edges after the start edge) from the function definitions alone.
  function automatic void model(input int y, input int s, output int b, output int e,
                                output int lat, output bit valid);
    int f;
    valid = (s == 1 || s == 2);
    b = 0; e = 0; lat = 1;
    if (!valid) return;
    for (int x = 0; x < 16; x++) begin
      f = (s == 1) ? 2*x + 2 : x*x;
      if (f == y) begin b = x; e = 1; lat = x + 2; return; end
      if (f > y) begin
`ifdef INV_FLOOR_EN
        b = (x > 0) ? x - 1 : 0;
`endif
        lat = x + 2; return;
      end
    end
`ifdef INV_FLOOR_EN
    b = 15;
`endif
    lat = 17;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), exp_busy);
      chk("done", int'(done), exp_done);
      chk("binario", int'(binario), exp_bin);
      chk("encontrado", int'(encontrado), exp_enc);
    end
  end

  task automatic run_op(input int y, input int s, input int restart_at, input int reset_at);
    int b, e, lat;
    bit valid;
    model(y, s, b, e, lat, valid);
    @(negedge clk);
    resultado = 8'(y); selectorOperacion = 2'(s); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; resultado = 8'($urandom); selectorOperacion = 2'($urandom);
    exp_busy = 0; exp_done = 0;
    if (lat == 1) begin exp_bin = b; exp_enc = e; end
    for (int n = 1; n <= lat + 2; n++) begin
      if (n == restart_at) begin
        start = 1'b1; resultado = 8'd4; selectorOperacion = 2'b10;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (n == reset_at) begin
        rst_n = 1'b0; #1;
        exp_bin = 0; exp_enc = 0; exp_busy = 0; exp_done = 0;
        chk("rst_bin", int'(binario), 0);
        chk("rst_enc", int'(encontrado), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        return;
      end
      exp_busy = (valid && n <= lat - 1) ? 1 : 0;
      exp_done = (n == lat) ? 1 : 0;
      if (n == lat - 1) begin exp_bin = b; exp_enc = e; end
    end
  endtask

  initial begin
    int b, e, lat;
    bit v;
    rst_n = 1'b0; start = 1'b0; resultado = '0; selectorOperacion = '0;

    model(49, 2, b, e, lat, v);
    chk("model49_b", b, 7); chk("model49_e", e, 1); chk("model49_lat", lat, 9);
    model(20, 1, b, e, lat, v);
    chk("model20_b", b, 9); chk("model20_lat", lat, 11);
    model(50, 2, b, e, lat, v);
    chk("model50_lat", lat, 10); chk("model50_e", e, 0);
    model(226, 2, b, e, lat, v);
    chk("model226_lat", lat, 17);
    model(0, 3, b, e, lat, v);
    chk("model_inv_lat", lat, 1);

    #2;
    chk("reset_bin", int'(binario), 0);
    chk("reset_enc", int'(encontrado), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    run_op(49, 2, -1, -1);
    chk("t1_bin", int'(binario), 7);
    chk("t1_enc", int'(encontrado), 1);
    run_op(20, 1, -1, -1);
    chk("t2_bin", int'(binario), 9);
    run_op(32, 1, -1, -1);
    chk("t2b_bin", int'(binario), 15);
    run_op(50, 2, -1, -1);
`ifdef INV_FLOOR_EN
    chk("t3_bin", int'(binario), 7);
`else
    chk("t3_bin", int'(binario), 0);
`endif
    chk("t3_enc", int'(encontrado), 0);
    run_op(226, 2, -1, -1);
`ifdef INV_FLOOR_EN
    chk("t4_bin", int'(binario), 15);
`else
    chk("t4_bin", int'(binario), 0);
`endif
    run_op(36, 2, -1, -1);
    run_op(0, 0, -1, -1);
    chk("t5_bin", int'(binario), 0);
    run_op(77, 3, -1, -1);
    run_op(0, 2, -1, -1);
    run_op(1, 1, -1, -1);
    run_op(4, 1, -1, -1);
    run_op(225, 2, 3, 5);
    run_op(49, 2, -1, -1);
    chk("t6_after_bin", int'(binario), 7);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
